// File: rtl/sram_dff_v1b.sv
// rtl/sram_dff_v1b.sv - 8x32 flip-flop single-port RAM, synchronous write, registered read
module sram_dff_v1b #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] add,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wd,
    output logic [DATA_WIDTH-1:0] rd
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Storage has no reset: contents stay undefined until written and survive resetn pulses.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] rd_d;

    // Write port: a write is dropped when its edge coincides with resetn low.
    always_ff @(posedge clk) begin
        if (resetn && we) begin
            mem_q[add] <= wd;
        end
    end

    // Read-data next state: a read cycle loads the pre-edge array word, a write cycle holds.
    always_comb begin
        rd_d = rd_q;
        if (!we) begin
            rd_d = mem_q[add];
        end
    end

    // Read-data register: only state in the block that is reset, cleared asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign rd = rd_q;

endmodule

// File: tb/tb_sram_dff_v1b.sv
// tb/tb_sram_dff_v1b.sv - self-checking bench for sram_dff_v1b against an array reference model
module tb_sram_dff_v1b;

    logic        clk;
    logic        resetn;
    logic [2:0]  add;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;

    int n_pass;
    int n_total;

    // Reference model: a plain array plus the last value a read returned.
    logic [31:0] ref_mem [8];
    logic [31:0] ref_rd;

    sram_dff_v1b #(
        .ADDR_WIDTH(3),
        .DATA_WIDTH(32)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .add    (add),
        .we     (we),
        .wd     (wd),
        .rd     (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    // One clock cycle of stimulus; inputs change 1ns after an edge, model follows the edge.
    task automatic tick(input logic t_we, input logic [2:0] t_add, input logic [31:0] t_wd);
        we  = t_we;
        add = t_add;
        wd  = t_wd;
        @(posedge clk);
        if (resetn) begin
            if (t_we) ref_mem[t_add] = t_wd;
            else      ref_rd = ref_mem[t_add];
        end else begin
            ref_rd = 32'h0;
        end
        #1;
    endtask

    task automatic test_reset();
        we = 1'b0; add = 3'd0; wd = 32'h0;
        #1;
        n_total++;
        if (rd !== 32'h0) $display("FAIL reset_initial rd=%h expected=%h", rd, 32'h0);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_total++;
            if (rd !== 32'h0) $display("FAIL reset_hold_%0d rd=%h expected=%h", i, rd, 32'h0);
            else n_pass++;
        end
        ref_rd = 32'h0;
        resetn = 1'b1;
    endtask

    task automatic test_write_read();
        tick(1'b1, 3'd3, 32'hDEADBEEF);
        tick(1'b0, 3'd3, 32'h0);
        n_total++;
        if (rd !== 32'hDEADBEEF) $display("FAIL write_read rd=%h expected=%h", rd, 32'hDEADBEEF);
        else n_pass++;
        tick(1'b0, 3'd3, 32'h0);
        n_total++;
        if (rd !== 32'hDEADBEEF) $display("FAIL write_read_stable rd=%h expected=%h", rd, 32'hDEADBEEF);
        else n_pass++;
    endtask

    task automatic test_sweep();
        for (int k = 0; k < 8; k++) tick(1'b1, 3'(k), 32'h1000_0000 + 32'(k));
        for (int k = 7; k >= 0; k--) begin
            tick(1'b0, 3'(k), 32'h0);
            n_total++;
            if (rd !== 32'h1000_0000 + 32'(k))
                $display("FAIL sweep_read_%0d rd=%h expected=%h", k, rd, 32'h1000_0000 + 32'(k));
            else n_pass++;
        end
    endtask

    task automatic test_overwrite_hold();
        tick(1'b1, 3'd5, 32'hA5A5A5A5);
        tick(1'b1, 3'd5, 32'h5A5A5A5A);
        tick(1'b0, 3'd5, 32'h0);
        n_total++;
        if (rd !== 32'h5A5A5A5A) $display("FAIL overwrite rd=%h expected=%h", rd, 32'h5A5A5A5A);
        else n_pass++;
        tick(1'b1, 3'd2, $urandom);
        n_total++;
        if (rd !== 32'h5A5A5A5A) $display("FAIL hold_during_write rd=%h expected=%h", rd, 32'h5A5A5A5A);
        else n_pass++;
        tick(1'b0, 3'd2, 32'h0);
        n_total++;
        if (rd !== ref_mem[2]) $display("FAIL readback_addr2 rd=%h expected=%h", rd, ref_mem[2]);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        tick(1'b0, 3'd7, 32'h0);
        #2;
        resetn = 1'b0;
        #1;
        n_total++;
        if (rd !== 32'h0) $display("FAIL async_reset_immediate rd=%h expected=%h", rd, 32'h0);
        else n_pass++;
        tick(1'b1, 3'd4, 32'hFFFF_FFFF);
        n_total++;
        if (rd !== 32'h0) $display("FAIL reset_held_edge rd=%h expected=%h", rd, 32'h0);
        else n_pass++;
        #2;
        resetn = 1'b1;
        tick(1'b0, 3'd4, 32'h0);
        n_total++;
        if (rd !== 32'h1000_0004) $display("FAIL retained_after_reset rd=%h expected=%h", rd, 32'h1000_0004);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
            n_total++;
            if (rd !== ref_rd) begin
                errs++;
                $display("FAIL random_%0d rd=%h expected=%h", i, rd, ref_rd);
            end else n_pass++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        resetn  = 1'b0;
        we      = 1'b0;
        add     = 3'd0;
        wd      = 32'h0;
        test_reset();
        test_write_read();
        test_sweep();
        test_overwrite_hold();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
